// File: rtl/mac_reg_slave.sv
// mac_reg_slave: MAC configuration register responder with a clause-22 MDIO bridge at 0x80-0x9F.
module mac_reg_slave #(
  parameter int          MDC_DIV      = 25,
  parameter int          RESET_CYCLES = 16,
  parameter logic [31:0] REV          = 32'h0000_0901
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   reg_addr,
  input  logic         reg_rd,
  input  logic         reg_wr,
  input  logic [31:0]  reg_writedata,
  output logic [31:0]  reg_readdata,
  output logic         reg_busy,
  output logic [31:0]  cmd_config,
  output logic         sw_reset,
  output logic [47:0]  mac_addr,
  output logic [127:0] fifo_thresh,
  output logic         mdc,
  output logic         mdio_out,
  output logic         mdio_oen,
  input  logic         mdio_in
);
  localparam int DW = $clog2(MDC_DIV + 1);
  localparam int RW = $clog2(RESET_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, LOCAL, MDIO, GAP} state_t;
  state_t            state_q, state_d;
  logic              gap_q, gap_d, wr_q, wr_d, busy_q, busy_d, pre_q, pre_d;
  logic              mdc_q, mdc_d, out_q, out_d, oen_q, oen_d;
  logic [7:0]        addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d, scratch_q, scratch_d;
  logic [31:0]       cmd_q, cmd_d, mac0_q, mac0_d, rval;
  logic [15:0]       mac1_q, mac1_d, rd_q, rd_d;
  logic [7:0][15:0]  thr_q, thr_d;
  logic [4:0]        phy_q, phy_d;
  logic [RW-1:0]     rcnt_q, rcnt_d;
  logic [DW-1:0]     div_q, div_d;
  logic [6:0]        bit_q, bit_d;
  logic [63:0]       sh_q, sh_d, frame;
  logic [2:0]        tidx;
  logic              is_thr;
  assign tidx   = 3'(addr_q - 8'd7);
  assign is_thr = addr_q >= 8'h07 && addr_q <= 8'h0E;
  assign frame  = {32'hFFFF_FFFF, 2'b01, reg_wr ? 2'b01 : 2'b10, phy_q, reg_addr[4:0], 2'b10, reg_writedata[15:0]};
  always_comb begin
    rval = is_thr ? {16'b0, thr_q[tidx]} : '0;
    case (addr_q)
      8'h00:   rval = REV;
      8'h01:   rval = scratch_q;
      8'h02:   rval = cmd_q;
      8'h03:   rval = mac0_q;
      8'h04:   rval = {16'b0, mac1_q};
      8'h0F:   rval = {27'b0, phy_q};
      default: ;
    endcase
  end
  always_comb begin
    state_d = state_q; gap_d = gap_q; addr_d = addr_q; wdata_d = wdata_q; wr_d = wr_q;
    busy_d = busy_q; rdata_d = rdata_q; scratch_d = scratch_q; cmd_d = cmd_q; mac0_d = mac0_q;
    mac1_d = mac1_q; thr_d = thr_q; phy_d = phy_q; rcnt_d = rcnt_q; mdc_d = mdc_q; div_d = div_q;
    bit_d = bit_q; sh_d = sh_q; rd_d = rd_q; oen_d = oen_q; out_d = out_q; pre_d = pre_q;
    if (cmd_q[13]) begin
      if (rcnt_q == '0) cmd_d[13] = 1'b0;
      else rcnt_d = rcnt_q - 1'b1;
    end
    case (state_q)
      IDLE: if (reg_rd | reg_wr) begin
        addr_d  = reg_addr;
        wdata_d = reg_writedata;
        wr_d    = reg_wr;
        busy_d  = 1'b1;
        state_d = reg_addr[7] ? MDIO : LOCAL;
        if (reg_addr[7]) begin
          out_d = frame[63];
          sh_d  = {frame[62:0], 1'b1};
          oen_d = 1'b1;
          bit_d = '0;
          div_d = '0;
          rd_d  = '0;
          mdc_d = 1'b0;
          pre_d = 1'b1;
        end
      end
      LOCAL: begin
        busy_d  = 1'b0;
        rdata_d = rval;
        state_d = GAP;
        gap_d   = 1'b0;
        if (wr_q) begin
          if (is_thr) thr_d[tidx] = wdata_q[15:0];
          case (addr_q)
            8'h01: scratch_d = wdata_q;
            8'h02: begin cmd_d = wdata_q; rcnt_d = RW'(RESET_CYCLES - 1); end
            8'h03: mac0_d = wdata_q;
            8'h04: mac1_d = wdata_q[15:0];
            8'h0F: phy_d = wdata_q[4:0];
            default: ;
          endcase
        end
      end
      MDIO: begin
        // the first MDIO cycle only presents bit 0 so mdc starts its low phase one cycle later
        if (pre_q) pre_d = 1'b0;
        else if (div_q != DW'(MDC_DIV - 1)) div_d = div_q + 1'b1;
        else begin
          div_d = '0;
          mdc_d = ~mdc_q;
          if (!mdc_q) begin
            if (!wr_q && bit_q >= 7'd48 && !bit_q[6]) rd_d = {rd_q[14:0], mdio_in};
          end else if (bit_q == 7'd64) begin
            mdc_d   = 1'b0;
            busy_d  = 1'b0;
            rdata_d = {16'b0, rd_q};
            state_d = GAP;
            gap_d   = 1'b0;
          end else begin
            bit_d = bit_q + 1'b1;
            out_d = sh_q[63];
            sh_d  = {sh_q[62:0], 1'b1};
            oen_d = bit_q != 7'd63 && (wr_q || bit_q < 7'd45);
          end
        end
      end
      GAP: begin
        gap_d = 1'b1;
        if (gap_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE; gap_q <= 1'b0; addr_q <= '0; wdata_q <= '0; wr_q <= 1'b0; busy_q <= 1'b0;
      rdata_q <= '0; scratch_q <= '0; cmd_q <= '0; mac0_q <= '0; mac1_q <= '0; thr_q <= '0;
      phy_q <= '0; rcnt_q <= '0; mdc_q <= 1'b0; div_q <= '0; bit_q <= '0; sh_q <= '0; rd_q <= '0;
      oen_q <= 1'b0; out_q <= 1'b1; pre_q <= 1'b0;
    end else begin
      state_q <= state_d; gap_q <= gap_d; addr_q <= addr_d; wdata_q <= wdata_d; wr_q <= wr_d;
      busy_q <= busy_d; rdata_q <= rdata_d; scratch_q <= scratch_d; cmd_q <= cmd_d; mac0_q <= mac0_d;
      mac1_q <= mac1_d; thr_q <= thr_d; phy_q <= phy_d; rcnt_q <= rcnt_d; mdc_q <= mdc_d;
      div_q <= div_d; bit_q <= bit_d; sh_q <= sh_d; rd_q <= rd_d; oen_q <= oen_d; out_q <= out_d;
      pre_q <= pre_d;
    end
  end
  assign reg_readdata = rdata_q;
  assign reg_busy     = busy_q;
  assign sw_reset     = cmd_q[13];
  assign cmd_config   = {cmd_q[31:2], cmd_q[13] ? 2'b00 : cmd_q[1:0]};
  assign mac_addr     = {mac1_q, mac0_q};
  assign fifo_thresh  = thr_q;
  assign mdc          = mdc_q;
  assign mdio_out     = out_q;
  assign mdio_oen     = oen_q;
endmodule

// File: doc/mac_reg_slave.md
# mac_reg_slave

Register-access responder for the MAC configuration port. It accepts the level-held rd/wr + busy-handshake requests issued by the MAC bring-up sequencer, or by any other initiator on the same port, and holds the MAC configuration registers. It also bridges word addresses 0x80–0x9F to a clause-22 MDIO master so PHY registers are reached through the same port. It sits between the sequencer and the MAC datapath/PHY pins.

## Interface
- MDC_DIV, 25: half-period of mdc in clk cycles (125 MHz → 2.5 MHz).
- RESET_CYCLES, 16: clk cycles for which the command_config software-reset bit (bit 13) stays set.
- REV, 32'h0000_0901: value returned at address 0x00.

Ports (clock and reset first):
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- reg_addr  in  8  word address; sampled at request accept.
- reg_rd  in  1  read request; level, held by the initiator.
- reg_wr  in  1  write request; level, held by the initiator; wins over reg_rd.
- reg_writedata  in  32  write data.
- reg_readdata  out  32  read data; valid when reg_busy falls, held until the next accept.
- reg_busy  out  1  high while a request is in service.
- cmd_config  out  32  command_config register; bits 0/1 (tx/rx enable) are forced to 0 while sw_reset=1.
- sw_reset  out  1  equals command_config[13].
- mac_addr  out  48  {mac_1[15:0], mac_0[31:0]}.
- fifo_thresh  out  128  eight 16-bit thresholds for addresses 0x07..0x0E; slot k = bits [16k+15:16k].
- mdc  out  1  MDIO clock.
- mdio_out  out  1  MDIO data out.
- mdio_oen  out  1  1 = drive the mdio pad.
- mdio_in  in  1  MDIO data in.

## Operation
- Reset values: all registers 0, reg_readdata 0, reg_busy 0, sw_reset 0, mdc 0, mdio_out 1, mdio_oen 0, FSM in IDLE with no gap pending.
- FSM states: IDLE, LOCAL, MDIO, GAP.
- IDLE → accept when (reg_rd|reg_wr) and no gap is pending. On accept, latch addr, data and op; reg_busy←1; go to LOCAL if addr<0x80, else MDIO.
- LOCAL, one cycle: perform the access, load reg_readdata, reg_busy←0, go to GAP.
- GAP, two cycles with reg_busy=0: reg_rd/reg_wr are ignored, which gives the initiator time to present the next address. Then go to IDLE.
- Register map:
  - 0x00 REV (RO).
  - 0x01 scratch (RW).
  - 0x02 command_config (RW). Writing bit13=1 starts the reset counter; bit 13 self-clears after RESET_CYCLES.
  - 0x03 mac_0 (RW 32).
  - 0x04 mac_1 (RW, 16 LSBs).
  - 0x07–0x0E thresholds (RW, 16 LSBs).
  - 0x0F phy_addr (RW, 5 LSBs).
  - Unmapped addresses below 0x80 read 0; writes to them are ignored.
- Read of a register returns its stored value, zero-extended. A read of 0x02 during software reset shows bit13=1.
- A write of 0x02 while the reset counter runs: the new value is stored, and bit13=1 restarts the count.
- MDIO (addr 0x80–0x9F): clause-22 frame to PHY address phy_addr, register addr[4:0].
  - Frame: 32×'1' preamble, ST=01, OP=01 (write) or 10 (read), PHYAD, REGAD, TA, 16 data bits, MSB first.
  - mdio_out changes after an mdc falling edge; mdio_in is sampled on the mdc rising edge.
  - Write: TA=10 driven, mdio_oen=1 for all 64 bits.
  - Read: mdio_oen=0 from the TA bits onward; the 16 sampled bits go to reg_readdata[15:0], with [31:16]=0.
  - After the frame: one idle mdc period with mdio_oen=0, then reg_busy←0 and go to GAP.
- Simultaneous reg_rd and reg_wr: treated as a write.
- rst mid-transaction aborts immediately and restores all reset values; the MDIO pad is released.

## Timing
- Request visible in IDLE at cycle N → reg_busy=1 at N+1.
- Local access: reg_busy=0 and reg_readdata valid at N+2; next possible accept at N+4.
- MDIO access: mdc starts low at N+2 and runs 65 periods of 2·MDC_DIV clk cycles. reg_busy falls at N+2+130·MDC_DIV.
- mdc toggles every MDC_DIV cycles, only in MDIO state; otherwise mdc is held at 0.
- sw_reset rises the cycle after the accepting edge of the write and stays high exactly RESET_CYCLES cycles.
- reg_readdata changes only in the cycle reg_busy falls.

## Test plan
- Reset, then read 0x00 → reg_readdata=0x0000_0901. Busy is high for exactly 1 cycle; a 2-cycle gap follows before the next accept.
- Held reg_wr, initiator advancing the address one cycle after busy falls: writes 0x06150910 to 0x03 and 0x2019 to 0x04 → mac_addr=48'h2019_0615_0910, no request is lost or duplicated.
- Write 0x04002030 to 0x02, then poll 0x02 → bit13 reads 1 for the first polls, and reads 0 after RESET_CYCLES=16. cmd_config[1:0]=0 while sw_reset=1.
- Write 0x0c00 to 0x89 with phy_addr=0x10 (MDC_DIV=2) → MDIO frame checked bit by bit: 32 ones, 01, 01, 10000, 01001, 10, 0x0c00. reg_busy low at N+262.
- Read 0x82 while the PHY model returns 0x141 → reg_readdata=0x0000_0141. mdio_oen=0 from the TA bits onward.
- Assert rst mid-MDIO frame → next cycle reg_busy=0, mdio_oen=0, mdc=0, all registers 0. A following read of 0x01 returns 0.
